// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter that owns a single W-bit holding register shared by
//   N requesters. One requester at a time is granted. Its data is loaded into
//   q, and q is held for HOLD extra cycles before the next arbitration.
//
// Handshake: requester i transfers on a rising clk edge where
//   req_valid[i] && req_ready[i]. req_ready is one-hot or zero and is a
//   decode of registered state, gated only by clr. A requester that drops
//   valid while granted simply loses that grant.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of q and the FSM (priority pointer kept)
//   req_valid  [N]    per-requester valid
//   req_data   [N*W]  requester i data at [i*W +: W]
//   req_ready  [N]    one-hot accept
//   q          [W]    shared register
//   q_owner    [OW]   requester that last loaded q
//   q_valid    q holds data loaded since reset/clr
//   upd        one-cycle pulse in the cycle after a load
//   fsm_state  [2]    debug view of the FSM (0 idle, 1 grant, 2 hold)
module shared_reg_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 2,
  localparam int OW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic [W-1:0]   q,
  output logic [OW-1:0]  q_owner,
  output logic           q_valid,
  output logic           upd,
  output logic [1:0]     fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_CNT = 4'(HOLD);

  state_t         state;
  logic [OW-1:0]  gnt;
  logic [OW-1:0]  last;
  logic [3:0]     cnt;

  logic           pick_found;
  logic [OW-1:0]  pick_idx;
  logic [OW-1:0]  cand_w;
  int             cand;
  logic [W-1:0]   gnt_data;
  logic           gnt_valid;

  // Round-robin search: first valid index at last+1, last+2, ... mod N.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_w     = '0;
    for (int i = 1; i <= N; i++) begin
      cand   = (int'(last) + i) % N;
      cand_w = OW'(cand);
      if (!pick_found && req_valid[cand_w]) begin
        pick_found = 1'b1;
        pick_idx   = cand_w;
      end
    end
  end

  // Data and valid of the currently granted requester.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (OW'(i) == gnt) gnt_data = req_data[i*W +: W];
    end
    gnt_valid = req_valid[gnt];
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_GRANT && !clr) req_ready[gnt] = 1'b1;
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      last    <= OW'(N - 1);
      cnt     <= '0;
      q       <= '0;
      q_owner <= '0;
      q_valid <= 1'b0;
      upd     <= 1'b0;
    end else if (clr) begin
      // Pointer survives a clear so fairness is not reset by software.
      state   <= ST_IDLE;
      cnt     <= '0;
      q       <= '0;
      q_owner <= '0;
      q_valid <= 1'b0;
      upd     <= 1'b0;
    end else begin
      upd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            gnt   <= pick_idx;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (gnt_valid) begin
            q       <= gnt_data;
            q_owner <= gnt;
            q_valid <= 1'b1;
            upd     <= 1'b1;
            last    <= gnt;
            if (HOLD == 0) begin
              state <= ST_IDLE;
            end else begin
              cnt   <= HOLD_CNT;
              state <= ST_HOLD;
            end
          end else begin
            // Withdrawn request: no transfer, pointer untouched.
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HOLD = 2;
  localparam int OW   = 2;

  logic           clk;
  logic           rst_n;
  logic           clr;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   q;
  logic [OW-1:0]  q_owner;
  logic           q_valid;
  logic           upd;
  logic [1:0]     fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries: {owner, data} expected on each upd pulse.
  logic [OW+W-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   exp_ready;
    logic [OW-1:0]  exp_owner;
    logic [W-1:0]   exp_q;
  } vec_t;

  vec_t vecs[8];

  shared_reg_arbiter #(.N(N), .W(W), .HOLD(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .q         (q),
    .q_owner   (q_owner),
    .q_valid   (q_valid),
    .upd       (upd),
    .fsm_state (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q"}, 32'(q), 32'h0);
    chk({tag, "_owner"}, 32'(q_owner), 32'h0);
    chk({tag, "_q_valid"}, 32'(q_valid), 32'h0);
    chk({tag, "_upd"}, 32'(upd), 32'h0);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : sb_mon
    logic [OW+W-1:0] e;
    if (rst_n && upd === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_upd: got q=%0h owner=%0d expected no load", q, q_owner);
      end else begin
        e = exp_q.pop_front();
        chk("sb_q", 32'(q), 32'(e[W-1:0]));
        chk("sb_owner", 32'(q_owner), 32'(e[OW+W-1:W]));
        chk("sb_q_valid", 32'(q_valid), 32'h1);
      end
    end
  end

  // Driver: one full transaction from an IDLE cycle back to the next IDLE cycle.
  task automatic run_vec(input vec_t v);
    req_valid = v.valid;
    req_data  = v.data;
    @(negedge clk);
    chk("vec_idle_ready", 32'(req_ready), 32'h0);
    chk("vec_idle_state", 32'(fsm_state), 32'h0);
    next_cycle();
    // GRANT: losers' data is scrambled, it must be ignored
    for (int i = 0; i < N; i++)
      if (i != int'(v.exp_owner)) req_data[i*W +: W] = W'($urandom_range(0, 255));
    exp_q.push_back({v.exp_owner, v.exp_q});
    @(negedge clk);
    chk("vec_grant_ready", 32'(req_ready), 32'(v.exp_ready));
    chk("vec_grant_state", 32'(fsm_state), 32'h1);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("vec_hold1_upd", 32'(upd), 32'h1);
    chk("vec_hold1_q", 32'(q), 32'(v.exp_q));
    chk("vec_hold1_ready", 32'(req_ready), 32'h0);
    chk("vec_hold1_state", 32'(fsm_state), 32'h2);
    next_cycle();
    @(negedge clk);
    chk("vec_hold2_upd", 32'(upd), 32'h0);
    chk("vec_hold2_q", 32'(q), 32'(v.exp_q));
    chk("vec_hold2_state", 32'(fsm_state), 32'h2);
    next_cycle();
    @(negedge clk);
    chk("vec_back_idle", 32'(fsm_state), 32'h0);
    next_cycle();
  endtask

  initial begin
    // Pointer starts at N-1 after reset; expected winners hand-derived in order.
    vecs[0] = '{4'b0100, 32'h13121110, 4'b0100, 2'd2, 8'h12};
    vecs[1] = '{4'b1111, 32'h23222120, 4'b1000, 2'd3, 8'h23};
    vecs[2] = '{4'b0110, 32'h33323130, 4'b0010, 2'd1, 8'h31};
    vecs[3] = '{4'b0011, 32'h43424140, 4'b0001, 2'd0, 8'h40};
    vecs[4] = '{4'b0011, 32'h53525150, 4'b0010, 2'd1, 8'h51};
    vecs[5] = '{4'b1001, 32'h63626160, 4'b1000, 2'd3, 8'h63};
    vecs[6] = '{4'b1000, 32'h73727170, 4'b1000, 2'd3, 8'h73};
    vecs[7] = '{4'b1010, 32'h83828180, 4'b0010, 2'd1, 8'h81};

    // Reset with random inputs
    rst_n     = 1'b0;
    clr       = 1'($urandom_range(0, 1));
    req_valid = N'($urandom_range(0, 15));
    req_data  = $urandom();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    chk("rst_state", 32'(fsm_state), 32'h0);
    clr       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rst_n     = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_zero("post_rst");
      next_cycle();
    end

    // Table-driven transactions
    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Round robin with all requests held, after a reset pulse
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'hD3D2D1D0;
    for (int t = 0; t < 24; t++) begin
      logic [N-1:0] er;
      logic [OW-1:0] ow;
      ow = OW'((t / 4) % 4);
      er = (t % 4 == 1) ? (N'(1) << ow) : '0;
      if (t % 4 == 1) exp_q.push_back({ow, 8'hD0 + 8'(ow)});
      @(negedge clk);
      chk("rr_ready", 32'(req_ready), 32'(er));
      next_cycle();
    end
    req_valid = '0;

    // Withdrawal: requester 1 drops valid while granted (pointer at 1)
    req_valid = 4'b0010;
    req_data  = 32'hE3E2E1E0;
    @(negedge clk);
    chk("wd_idle_ready", 32'(req_ready), 32'h0);
    next_cycle();
    req_valid = 4'b0101;
    @(negedge clk);
    chk("wd_grant_ready", 32'(req_ready), 32'h2);
    next_cycle();
    @(negedge clk);
    chk("wd_back_idle", 32'(fsm_state), 32'h0);
    chk("wd_no_upd", 32'(upd), 32'h0);
    chk("wd_q_kept", 32'(q), 32'hD1);
    chk("wd_owner_kept", 32'(q_owner), 32'h1);
    next_cycle();
    exp_q.push_back({2'd2, 8'hE2});
    @(negedge clk);
    chk("wd_next_grant", 32'(req_ready), 32'h4);
    next_cycle();
    req_valid = '0;
    repeat (2) next_cycle();

    // clr in GRANT with valid high (pointer at 2 -> requester 3)
    req_valid = 4'b1000;
    req_data  = 32'hF3F2F1F0;
    next_cycle();
    clr = 1'b1;
    @(negedge clk);
    chk("clr_grant_ready", 32'(req_ready), 32'h0);
    next_cycle();
    clr       = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("clr_grant_q", 32'(q), 32'h0);
    chk("clr_grant_q_valid", 32'(q_valid), 32'h0);
    chk("clr_grant_owner", 32'(q_owner), 32'h0);
    chk("clr_grant_upd", 32'(upd), 32'h0);
    chk("clr_grant_state", 32'(fsm_state), 32'h0);
    next_cycle();
    exp_q.push_back({2'd1, 8'hF1});
    @(negedge clk);
    chk("clr_load1_ready", 32'(req_ready), 32'h2);
    next_cycle();
    // clr during HOLD
    req_valid = '0;
    clr       = 1'b1;
    @(negedge clk);
    chk("clr_hold_state", 32'(fsm_state), 32'h2);
    next_cycle();
    clr       = 1'b0;
    req_valid = 4'b0111;
    @(negedge clk);
    chk("clr_hold_idle", 32'(fsm_state), 32'h0);
    chk("clr_hold_q", 32'(q), 32'h0);
    chk("clr_hold_q_valid", 32'(q_valid), 32'h0);
    next_cycle();
    exp_q.push_back({2'd2, 8'hF2});
    @(negedge clk);
    chk("clr_ptr_kept", 32'(req_ready), 32'h4);
    next_cycle();
    req_valid = '0;
    repeat (2) next_cycle();

    // Async reset during HOLD after a load from requester 3
    req_valid = 4'b1000;
    req_data  = 32'hC3C2C1C0;
    next_cycle();
    @(negedge clk);
    chk("ar_grant_ready", 32'(req_ready), 32'h8);
    next_cycle();
    req_valid = '0;
    chk("ar_loaded_q", 32'(q), 32'hC3);
    chk("ar_loaded_owner", 32'(q_owner), 32'h3);
    chk("ar_loaded_upd", 32'(upd), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("ar");
    chk("ar_state", 32'(fsm_state), 32'h0);
    req_valid = N'($urandom_range(0, 15));
    req_data  = $urandom();
    repeat (2) next_cycle();
    req_valid = '0;
    rst_n     = 1'b1;
    req_valid = 4'b1001;
    req_data  = 32'hB3B2B1B0;
    next_cycle();
    exp_q.push_back({2'd0, 8'hB0});
    @(negedge clk);
    chk("ar_first_grant", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = '0;
    repeat (4) next_cycle();

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
